// File: rtl/spi_responder_pkg.sv
// Shared types and constants for the SPI register-access responder.
package spi_responder_pkg;

    localparam int unsigned ADDR_BITS = 7;
    localparam int unsigned DATA_BITS = 8;
    localparam logic        RW_READ   = 1'b1;

    // Bit counter reload value: counts down from the MSB of a byte.
    localparam logic [2:0]  BIT_CNT_MSB = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_WDATA  = 3'd2,
        ST_RDATA  = 3'd3,
        ST_WAITCS = 3'd4
    } state_e;

    // Register addresses wrap from the top of the 7-bit space back to zero.
    function automatic logic [ADDR_BITS-1:0] addr_next(input logic [ADDR_BITS-1:0] addr);
        return addr + 7'd1;
    endfunction

endpackage

// File: rtl/spi_input_sync.sv
// Multi-flop synchroniser for one SPI pin with optional registered edge strobes.
// The level output is delayed one extra cycle so it lines up with the strobes:
// pin edge to strobe (and to level change) is SYNC_STAGES + 1 cycles.
module spi_input_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0,
    parameter bit          EDGES       = 1'b1
) (
    input  logic i_clock,
    input  logic i_resetn,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   level_q;
    logic                   level_d;
    logic                   rise_q;
    logic                   rise_d;
    logic                   fall_q;
    logic                   fall_d;

    // Next chain value and edge detection on the last synchroniser stage.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], i_pin};
        level_d = sync_q[SYNC_STAGES-1];
        if (EDGES) begin
            rise_d = level_d & ~level_q;
            fall_d = ~level_d & level_q;
        end else begin
            rise_d = 1'b0;
            fall_d = 1'b0;
        end
    end

    // Synchroniser chain, aligned level and strobe registers.
    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            sync_q  <= {SYNC_STAGES{RESET_VAL}};
            level_q <= RESET_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign o_level = level_q;
    assign o_rise  = rise_q;
    assign o_fall  = fall_q;

endmodule

// File: rtl/spi_responder.sv
// SPI responder: decodes 16-bit write/read frames into a local register port.
// Optional burst mode (address auto-increment) when SPI_RESPONDER_AUTOINC_EN is defined.
module spi_responder
    import spi_responder_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 i_clock,
    input  logic                 i_resetn,
    input  logic                 i_sen,
    input  logic                 i_sck,
    input  logic                 i_sdat,
    output logic                 o_sout,
    output logic                 o_wrValid,
    output logic [ADDR_BITS-1:0] o_wrAddr,
    output logic [DATA_BITS-1:0] o_wrData,
    output logic                 o_rdReq,
    output logic [ADDR_BITS-1:0] o_rdAddr,
    input  logic [DATA_BITS-1:0] i_rdData,
    output logic                 o_busy,
    output logic                 o_frameErr
);

    logic sen_lvl_s;
    logic sen_fall_s;
    logic sen_rise_unused_s;
    logic sck_rise_s;
    logic sck_fall_s;
    logic sck_level_unused_s;
    logic sdat_lvl_s;
    logic sdat_rise_unused_s;
    logic sdat_fall_unused_s;

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1), .EDGES(1'b1)) u_sync_sen (
        .i_clock (i_clock),
        .i_resetn(i_resetn),
        .i_pin   (i_sen),
        .o_level (sen_lvl_s),
        .o_rise  (sen_rise_unused_s),
        .o_fall  (sen_fall_s)
    );

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0), .EDGES(1'b1)) u_sync_sck (
        .i_clock (i_clock),
        .i_resetn(i_resetn),
        .i_pin   (i_sck),
        .o_level (sck_level_unused_s),
        .o_rise  (sck_rise_s),
        .o_fall  (sck_fall_s)
    );

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0), .EDGES(1'b0)) u_sync_sdat (
        .i_clock (i_clock),
        .i_resetn(i_resetn),
        .i_pin   (i_sdat),
        .o_level (sdat_lvl_s),
        .o_rise  (sdat_rise_unused_s),
        .o_fall  (sdat_fall_unused_s)
    );

    state_e                 state_q,     state_d;
    logic [2:0]             bit_cnt_q,   bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q,     shift_d;
    logic [ADDR_BITS-1:0]   addr_q,      addr_d;
    logic [DATA_BITS-1:0]   rd_shift_q,  rd_shift_d;
    logic                   rd_pend_q,   rd_pend_d;
    logic                   sout_q,      sout_d;
    logic                   wr_valid_q,  wr_valid_d;
    logic [ADDR_BITS-1:0]   wr_addr_q,   wr_addr_d;
    logic [DATA_BITS-1:0]   wr_data_q,   wr_data_d;
    logic                   rd_req_q,    rd_req_d;
    logic [ADDR_BITS-1:0]   rd_addr_q,   rd_addr_d;
    logic                   busy_q,      busy_d;
    logic                   frame_err_q, frame_err_d;
    logic [DATA_BITS-1:0]   cmd_byte_s;
    logic                   cs_done_ok_s;

`ifdef SPI_RESPONDER_AUTOINC_EN
    // Set once a full data byte has moved, so CS release on a byte boundary is clean.
    logic beat_q, beat_d;
    assign cs_done_ok_s = beat_q & (bit_cnt_q == BIT_CNT_MSB);
`else
    assign cs_done_ok_s = 1'b0;
`endif

    // Byte completed by the bit arriving on the current SCK rising strobe.
    assign cmd_byte_s = {shift_q[DATA_BITS-2:0], sdat_lvl_s};

    // Frame decoder: next state, shift registers and strobe outputs.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        addr_d      = addr_q;
        rd_pend_d   = rd_req_q;
        sout_d      = sout_q;
        wr_valid_d  = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rd_req_d    = 1'b0;
        rd_addr_d   = rd_addr_q;
        frame_err_d = 1'b0;
`ifdef SPI_RESPONDER_AUTOINC_EN
        beat_d      = beat_q;
`endif
        // Read data is captured the cycle after the request, ahead of the next SCK fall.
        if (rd_pend_q) begin
            rd_shift_d = i_rdData;
        end else begin
            rd_shift_d = rd_shift_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (sen_fall_s) begin
                    state_d   = ST_CMD;
                    bit_cnt_d = BIT_CNT_MSB;
`ifdef SPI_RESPONDER_AUTOINC_EN
                    beat_d    = 1'b0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_CMD: begin
                if (sen_lvl_s) begin
                    state_d     = ST_IDLE;
                    frame_err_d = 1'b1;
                end else if (sck_rise_s) begin
                    shift_d = cmd_byte_s;
                    if (bit_cnt_q == 3'd0) begin
                        addr_d    = cmd_byte_s[ADDR_BITS-1:0];
                        bit_cnt_d = BIT_CNT_MSB;
                        if (cmd_byte_s[DATA_BITS-1] == RW_READ) begin
                            rd_addr_d = cmd_byte_s[ADDR_BITS-1:0];
                            rd_req_d  = 1'b1;
                            state_d   = ST_RDATA;
                        end else begin
                            state_d   = ST_WDATA;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q - 3'd1;
                    end
                end else begin
                    state_d = ST_CMD;
                end
            end

            ST_WDATA: begin
                if (sen_lvl_s) begin
                    state_d     = ST_IDLE;
                    frame_err_d = ~cs_done_ok_s;
                end else if (sck_rise_s) begin
                    shift_d = cmd_byte_s;
                    if (bit_cnt_q == 3'd0) begin
                        wr_valid_d = 1'b1;
                        wr_addr_d  = addr_q;
                        wr_data_d  = cmd_byte_s;
`ifdef SPI_RESPONDER_AUTOINC_EN
                        addr_d     = addr_next(addr_q);
                        bit_cnt_d  = BIT_CNT_MSB;
                        beat_d     = 1'b1;
                        state_d    = ST_WDATA;
`else
                        state_d    = ST_WAITCS;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q - 3'd1;
                    end
                end else begin
                    state_d = ST_WDATA;
                end
            end

            ST_RDATA: begin
                if (sen_lvl_s) begin
                    state_d     = ST_IDLE;
                    frame_err_d = ~cs_done_ok_s;
                end else if (sck_fall_s) begin
                    sout_d     = rd_shift_q[DATA_BITS-1];
                    rd_shift_d = {rd_shift_q[DATA_BITS-2:0], 1'b0};
                end else if (sck_rise_s) begin
                    if (bit_cnt_q == 3'd0) begin
`ifdef SPI_RESPONDER_AUTOINC_EN
                        rd_addr_d = addr_next(rd_addr_q);
                        rd_req_d  = 1'b1;
                        bit_cnt_d = BIT_CNT_MSB;
                        beat_d    = 1'b1;
                        state_d   = ST_RDATA;
`else
                        state_d   = ST_WAITCS;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q - 3'd1;
                    end
                end else begin
                    state_d = ST_RDATA;
                end
            end

            ST_WAITCS: begin
                if (sen_lvl_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAITCS;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // MISO is only driven while a read byte is being shifted out.
        sout_d = (state_d == ST_RDATA) ? sout_d : 1'b0;
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset discards any frame in flight.
    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= BIT_CNT_MSB;
            shift_q     <= 8'h00;
            addr_q      <= 7'h00;
            rd_shift_q  <= 8'h00;
            rd_pend_q   <= 1'b0;
            sout_q      <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= 7'h00;
            wr_data_q   <= 8'h00;
            rd_req_q    <= 1'b0;
            rd_addr_q   <= 7'h00;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef SPI_RESPONDER_AUTOINC_EN
            beat_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            addr_q      <= addr_d;
            rd_shift_q  <= rd_shift_d;
            rd_pend_q   <= rd_pend_d;
            sout_q      <= sout_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_req_q    <= rd_req_d;
            rd_addr_q   <= rd_addr_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
`ifdef SPI_RESPONDER_AUTOINC_EN
            beat_q      <= beat_d;
`endif
        end
    end

    assign o_sout     = sout_q;
    assign o_wrValid  = wr_valid_q;
    assign o_wrAddr   = wr_addr_q;
    assign o_wrData   = wr_data_q;
    assign o_rdReq    = rd_req_q;
    assign o_rdAddr   = rd_addr_q;
    assign o_busy     = busy_q;
    assign o_frameErr = frame_err_q;

endmodule

// File: tb/tb_spi_responder.sv
// Directed testbench for spi_responder: SPI master model, strobe monitor and
// hand-computed expectations. Burst checks are built when SPI_RESPONDER_AUTOINC_EN is defined.
module tb_spi_responder;

    localparam int HALF = 15;  // CLOCKS_PER_BIT = 30
`ifdef SPI_RESPONDER_AUTOINC_EN
    localparam int RD_PER_FRAME = 2;  // burst mode pre-fetches the next address
`else
    localparam int RD_PER_FRAME = 1;
`endif

    logic       clk = 1'b0;
    logic       resetn;
    logic       sen;
    logic       sck;
    logic       sdat;
    logic       sout;
    logic       wr_valid;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_req;
    logic [6:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;
    logic       frame_err;

    int n_cmp = 0;
    int n_err = 0;

    int         wr_cnt = 0;
    int         rd_cnt = 0;
    int         err_cnt = 0;
    int         sout_bad = 0;
    bit         in_read = 1'b0;
    logic [6:0] wr_addr_log [16];
    logic [7:0] wr_data_log [16];
    logic [6:0] rd_addr_log [16];

    always #5 clk = ~clk;

    spi_responder #(.SYNC_STAGES(2)) dut (
        .i_clock   (clk),
        .i_resetn  (resetn),
        .i_sen     (sen),
        .i_sck     (sck),
        .i_sdat    (sdat),
        .o_sout    (sout),
        .o_wrValid (wr_valid),
        .o_wrAddr  (wr_addr),
        .o_wrData  (wr_data),
        .o_rdReq   (rd_req),
        .o_rdAddr  (rd_addr),
        .i_rdData  (rd_data),
        .o_busy    (busy),
        .o_frameErr(frame_err)
    );

    // Peripheral register contents returned for a read address.
    function automatic logic [7:0] rd_model(input logic [6:0] a);
        case (a)
            7'h7F:   rd_model = 8'h5C;
            7'h7E:   rd_model = 8'hE7;
            7'h00:   rd_model = 8'h3A;
            7'h12:   rd_model = 8'hC3;
            default: rd_model = 8'h99;
        endcase
    endfunction

    assign rd_data = rd_model(rd_addr);

    // Strobe monitor: logs every write/read request and error pulse.
    always @(negedge clk) begin
        if (wr_valid) begin
            wr_addr_log[wr_cnt[3:0]] <= wr_addr;
            wr_data_log[wr_cnt[3:0]] <= wr_data;
            wr_cnt <= wr_cnt + 1;
        end
        if (rd_req) begin
            rd_addr_log[rd_cnt[3:0]] <= rd_addr;
            rd_cnt <= rd_cnt + 1;
        end
        if (frame_err) err_cnt <= err_cnt + 1;
        if (sout && !in_read) sout_bad <= sout_bad + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Master: MSB-first from mosi[31], data changes while SCK low, MISO sampled on SCK rise.
    task automatic spi_xfer(input logic [31:0] mosi, input int nbits, input bit release_cs,
                            output logic [31:0] miso);
        miso = 32'h0;
        @(negedge clk);
        sen = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            sdat = mosi[31-i];
            repeat (HALF) @(negedge clk);
            sck = 1'b1;
            miso[31-i] = sout;
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        if (release_cs) begin
            sen = 1'b1;
            repeat (4 * HALF) @(negedge clk);
        end else begin
            sen = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] miso;
        int          w0;
        int          r0;
        int          e0;

        resetn = 1'b0;
        sen    = 1'b1;
        sck    = 1'b0;
        sdat   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {5'd0, sout, wr_valid, wr_addr, wr_data, rd_req, rd_addr, busy, frame_err}, 32'h0);
        resetn = 1'b1;
        repeat (10) @(negedge clk);

        // Plain write 0x05 <- 0xA3
        w0 = wr_cnt; e0 = err_cnt;
        spi_xfer({1'b0, 7'h05, 8'hA3, 16'h0}, 16, 1'b1, miso);
        check("wr1_count", 32'(wr_cnt - w0), 32'd1);
        check("wr1_addr", {25'd0, wr_addr_log[w0[3:0]]}, 32'h05);
        check("wr1_data", {24'd0, wr_data_log[w0[3:0]]}, 32'hA3);
        check("wr1_sout_idle", 32'(sout_bad), 32'd0);
        check("wr1_no_err", 32'(err_cnt - e0), 32'd0);
        check("wr1_busy_after", {31'd0, busy}, 32'd0);

        // Read at top of address space 0x7F
        w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
        in_read = 1'b1;
        spi_xfer({1'b1, 7'h7F, 8'h00, 16'h0}, 16, 1'b1, miso);
        in_read = 1'b0;
        check("rd1_count", 32'(rd_cnt - r0), 32'(RD_PER_FRAME));
        check("rd1_addr", {25'd0, rd_addr_log[r0[3:0]]}, 32'h7F);
        check("rd1_miso", {24'd0, miso[23:16]}, 32'h5C);
        check("rd1_no_write", 32'(wr_cnt - w0), 32'd0);

        // CS raised after 10 bits of a write: error pulse, no write
        w0 = wr_cnt; e0 = err_cnt;
        spi_xfer({1'b0, 7'h44, 8'h66, 16'h0}, 10, 1'b1, miso);
        check("abort_err", 32'(err_cnt - e0), 32'd1);
        check("abort_no_write", 32'(wr_cnt - w0), 32'd0);
        check("abort_idle", {31'd0, busy}, 32'd0);
        w0 = wr_cnt; e0 = err_cnt;
        spi_xfer({1'b0, 7'h33, 8'h5A, 16'h0}, 16, 1'b1, miso);
        check("post_abort_count", 32'(wr_cnt - w0), 32'd1);
        check("post_abort_wr", {17'd0, wr_addr_log[w0[3:0]], wr_data_log[w0[3:0]]}, {17'd0, 7'h33, 8'h5A});
        check("post_abort_no_err", 32'(err_cnt - e0), 32'd0);

        // Reset in the middle of a read frame
        in_read = 1'b1;
        spi_xfer({1'b1, 7'h12, 8'h00, 16'h0}, 12, 1'b0, miso);
        resetn = 1'b0;
        #1;
        check("midframe_reset", {5'd0, sout, wr_valid, wr_addr, wr_data, rd_req, rd_addr, busy, frame_err}, 32'h0);
        @(negedge clk);
        sen = 1'b1;
        sck = 1'b0;
        repeat (5) @(negedge clk);
        resetn = 1'b1;
        repeat (20) @(negedge clk);
        r0 = rd_cnt; e0 = err_cnt;
        spi_xfer({1'b1, 7'h12, 8'h00, 16'h0}, 16, 1'b1, miso);
        in_read = 1'b0;
        check("post_reset_rd_addr", {25'd0, rd_addr_log[r0[3:0]]}, 32'h12);
        check("post_reset_miso", {24'd0, miso[23:16]}, 32'hC3);
        check("post_reset_no_err", 32'(err_cnt - e0), 32'd0);

        // SCK activity with CS high is ignored
        w0 = wr_cnt; e0 = err_cnt;
        for (int i = 0; i < 10; i++) begin
            sdat = i[0];
            repeat (HALF) @(negedge clk);
            sck = 1'b1;
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        check("cs_high_idle", {31'd0, busy}, 32'd0);
        spi_xfer({1'b0, 7'h00, 8'hFF, 16'h0}, 16, 1'b1, miso);
        check("edge_wr_count", 32'(wr_cnt - w0), 32'd1);
        check("edge_wr", {17'd0, wr_addr_log[w0[3:0]], wr_data_log[w0[3:0]]}, {17'd0, 7'h00, 8'hFF});
        check("edge_no_err", 32'(err_cnt - e0), 32'd0);
        check("sout_quiet_total", 32'(sout_bad), 32'd0);

`ifdef SPI_RESPONDER_AUTOINC_EN
        // Burst write across the address wrap
        w0 = wr_cnt; e0 = err_cnt;
        spi_xfer({1'b0, 7'h7F, 8'h11, 8'h22, 8'h00}, 24, 1'b1, miso);
        check("burst_wr_count", 32'(wr_cnt - w0), 32'd2);
        check("burst_wr0", {17'd0, wr_addr_log[w0[3:0]], wr_data_log[w0[3:0]]}, {17'd0, 7'h7F, 8'h11});
        check("burst_wr1", {17'd0, wr_addr_log[4'(w0 + 1)], wr_data_log[4'(w0 + 1)]}, {17'd0, 7'h00, 8'h22});
        check("burst_wr_no_err", 32'(err_cnt - e0), 32'd0);

        // Burst read across the address wrap
        r0 = rd_cnt; e0 = err_cnt;
        in_read = 1'b1;
        spi_xfer({1'b1, 7'h7E, 24'h0}, 32, 1'b1, miso);
        in_read = 1'b0;
        check("burst_rd_data", {8'd0, miso[23:0]}, {8'd0, 8'hE7, 8'h5C, 8'h3A});
        check("burst_rd_addr0", {25'd0, rd_addr_log[r0[3:0]]}, 32'h7E);
        check("burst_rd_addr2", {25'd0, rd_addr_log[4'(r0 + 2)]}, 32'h00);
        check("burst_rd_no_err", 32'(err_cnt - e0), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
